// File: rtl/osc_freq_meter.sv
// ---------------------------------------------------------------------------
// osc_freq_meter
//
// Zero-crossing frequency / period / amplitude meter for the x output of a
// hopf_oscillator. Samples are taken only on clk_en. A hysteresis sign
// tracker (UNK/NEG/POS) turns the waveform into rising/falling events, which
// feed a per-window crossing count, a free-running rising-to-rising period
// counter and a per-window peak |x| tracker.
//
// Optional feature (macro OSC_FREQ_METER_DIR_EN): adds input y and output
// dir; on each rising event dir captures (y < 0), i.e. the rotation
// direction of the oscillator.
//
// Ports:
//   clk          system clock
//   rst          synchronous, active-high reset
//   clk_en       sample strobe; all state advances only when high
//   x            signed oscillator x sample (WIDTH bits)
//   y            signed oscillator y sample (only with OSC_FREQ_METER_DIR_EN)
//   dir          direction captured at the last rising event (only with macro)
//   crossings    rising+falling events in the last completed window
//   period_last  clk_en samples between the two most recent rising events
//   peak_abs     max |x| in the last completed window
//   meas_valid   one-cycle pulse after the window-closing sample
//   locked       set once two rising events have been seen since reset
//
// Handshake: meas_valid is a single-cycle qualifier with no ready; it is
// high in the cycle after the closing clk_en edge, and crossings/peak_abs
// hold their values until the next window closes.
// ---------------------------------------------------------------------------
module osc_freq_meter #(
    parameter int WIDTH  = 18,
    parameter int FRAC   = 14,
    parameter int WINDOW = 4000,
    parameter int HYST   = 64,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clk_en,
    input  logic signed [WIDTH-1:0] x,
`ifdef OSC_FREQ_METER_DIR_EN
    input  logic signed [WIDTH-1:0] y,
    output logic                    dir,
`endif
    output logic [CNT_W-1:0]        crossings,
    output logic [CNT_W-1:0]        period_last,
    output logic [WIDTH-1:0]        peak_abs,
    output logic                    meas_valid,
    output logic                    locked
);

    // FRAC only documents the x format; HYST is already in raw LSBs.
    if (FRAC < 0 || FRAC >= WIDTH || HYST <= 0 || WINDOW < 1) begin : g_bad_params
        $error("osc_freq_meter: illegal parameter combination");
    end

    localparam int WIN_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);

    localparam logic signed [WIDTH-1:0] HYST_P = WIDTH'(HYST);
    localparam logic signed [WIDTH-1:0] HYST_N = -HYST_P;
    localparam logic [WIDTH-1:0] X_MIN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] X_MAX = {1'b0, {(WIDTH-1){1'b1}}};

    localparam logic [1:0] S_UNK = 2'd0;
    localparam logic [1:0] S_NEG = 2'd1;
    localparam logic [1:0] S_POS = 2'd2;

    logic [1:0]       sign_state;
    logic [1:0]       sign_state_nxt;
    logic             rise;
    logic             fall;
    logic [WIN_W-1:0] win_cnt;
    logic             win_last;
    logic [CNT_W-1:0] acc;
    logic [CNT_W-1:0] acc_nxt;
    logic [WIDTH-1:0] peak_run;
    logic [WIDTH-1:0] peak_nxt;
    logic [WIDTH-1:0] x_abs;
    logic [CNT_W-1:0] per_cnt;
    logic [CNT_W-1:0] per_plus;
    logic             armed;

    // Hysteresis sign tracker. UNK only resolves to a sign; events need a
    // real NEG->POS or POS->NEG transition.
    always_comb begin
        sign_state_nxt = sign_state;
        rise           = 1'b0;
        fall           = 1'b0;
        if (x >= HYST_P) begin
            sign_state_nxt = S_POS;
            rise           = (sign_state == S_NEG);
        end else if (x <= HYST_N) begin
            sign_state_nxt = S_NEG;
            fall           = (sign_state == S_POS);
        end
    end

    // |x| with the most negative code clamped so it fits in WIDTH-1 bits.
    always_comb begin
        if (x == X_MIN)
            x_abs = X_MAX;
        else if (x[WIDTH-1])
            x_abs = ~x + 1'b1;
        else
            x_abs = x;
    end

    assign win_last = (win_cnt == WIN_LAST);
    assign acc_nxt  = ((rise || fall) && !(&acc)) ? acc + 1'b1 : acc;
    assign peak_nxt = (x_abs > peak_run) ? x_abs : peak_run;
    assign per_plus = (&per_cnt) ? per_cnt : per_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            sign_state  <= S_UNK;
            win_cnt     <= '0;
            acc         <= '0;
            peak_run    <= '0;
            per_cnt     <= '0;
            armed       <= 1'b0;
            crossings   <= '0;
            period_last <= '0;
            peak_abs    <= '0;
            meas_valid  <= 1'b0;
            locked      <= 1'b0;
`ifdef OSC_FREQ_METER_DIR_EN
            dir         <= 1'b0;
`endif
        end else begin
            meas_valid <= 1'b0;
            if (clk_en) begin
                sign_state <= sign_state_nxt;

                // Period counter runs across window boundaries; the first
                // rising event only arms it.
                if (rise) begin
                    per_cnt <= '0;
                    armed   <= 1'b1;
                    if (armed) begin
                        period_last <= per_plus;
                        locked      <= 1'b1;
                    end
`ifdef OSC_FREQ_METER_DIR_EN
                    dir <= y[WIDTH-1];
`endif
                end else begin
                    per_cnt <= per_plus;
                end

                // The closing sample is folded into the published results.
                if (win_last) begin
                    crossings  <= acc_nxt;
                    peak_abs   <= peak_nxt;
                    meas_valid <= 1'b1;
                    acc        <= '0;
                    peak_run   <= '0;
                    win_cnt    <= '0;
                end else begin
                    acc        <= acc_nxt;
                    peak_run   <= peak_nxt;
                    win_cnt    <= win_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_osc_freq_meter.sv
// ---------------------------------------------------------------------------
// tb_osc_freq_meter: bench for osc_freq_meter (default build; the direction
// test is compiled in only with OSC_FREQ_METER_DIR_EN).
// ---------------------------------------------------------------------------
module tb_osc_freq_meter;

    localparam int WIDTH  = 18;
    localparam int WINDOW = 4000;
    localparam int HYST   = 64;
    localparam int CNT_W  = 16;
    localparam int XMINV  = -(1 << (WIDTH-1));
    localparam int XMAXV  = (1 << (WIDTH-1)) - 1;
    localparam int CMAX   = (1 << CNT_W) - 1;

    // ---------------- clock / reset ----------------
    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    clk_en = 1'b0;
    logic signed [WIDTH-1:0] x = '0;
`ifdef OSC_FREQ_METER_DIR_EN
    logic signed [WIDTH-1:0] y = '0;
    logic                    dir;
`endif
    logic [CNT_W-1:0]        crossings;
    logic [CNT_W-1:0]        period_last;
    logic [WIDTH-1:0]        peak_abs;
    logic                    meas_valid;
    logic                    locked;

    always #5 clk = ~clk;

    osc_freq_meter #(
        .WIDTH(WIDTH), .FRAC(14), .WINDOW(WINDOW), .HYST(HYST), .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .clk_en(clk_en),
        .x(x),
`ifdef OSC_FREQ_METER_DIR_EN
        .y(y),
        .dir(dir),
`endif
        .crossings(crossings),
        .period_last(period_last),
        .peak_abs(peak_abs),
        .meas_valid(meas_valid),
        .locked(locked)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Works from sample indices: crossings are sign changes of the last
    // decisive (|x| >= HYST) sample, periods are differences of rising-event
    // sample indices.
    int   m_n;
    int   m_sign;          // 0 unknown, +1 / -1 last decisive sign
    int   m_rises[$];
    int   m_win_pos;
    int   m_acc;
    int   m_peak;
    int   m_period;
    bit   m_locked;
    logic [50:0] exp_q[$]; // {crossings[15:0], peak[17:0], period[15:0], locked}

    task automatic model_reset();
        m_n = 0; m_sign = 0; m_rises.delete(); m_win_pos = 0;
        m_acc = 0; m_peak = 0; m_period = 0; m_locked = 0;
        exp_q.delete();
    endtask

    task automatic model_sample(input int v);
        bit ev;
        int a;
        int d;
        ev = 0;
        if (v >= HYST) begin
            if (m_sign == -1) begin
                ev = 1;
                m_rises.push_back(m_n);
                if (m_rises.size() >= 2) begin
                    d = m_rises[m_rises.size()-1] - m_rises[m_rises.size()-2];
                    m_period = (d > CMAX) ? CMAX : d;
                    m_locked = 1;
                end
            end
            m_sign = 1;
        end else if (v <= -HYST) begin
            if (m_sign == 1) ev = 1;
            m_sign = -1;
        end
        if (ev && m_acc < CMAX) m_acc++;
        a = (v < 0) ? ((v == XMINV) ? XMAXV : -v) : v;
        if (a > m_peak) m_peak = a;
        m_n++;
        m_win_pos++;
        if (m_win_pos == WINDOW) begin
            exp_q.push_back({16'(m_acc), 18'(m_peak), 16'(m_period), m_locked});
            m_acc = 0; m_peak = 0; m_win_pos = 0;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step(input bit en, input int v);
        @(negedge clk);
        clk_en = en;
        x = v[WIDTH-1:0];
        if (en && !rst) model_sample(v);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; clk_en = 1'b0; x = '0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic int sq(input int i, input int half, input int amp);
        return (((i / half) % 2) == 0) ? amp : -amp;
    endfunction

    // ---------------- scoreboard / monitor ----------------
    int          pulse_cnt = 0;
    logic [50:0] snap;

    always @(negedge clk) begin
        logic [50:0] e;
        if (!rst && meas_valid) begin
            pulse_cnt++;
            snap = {crossings, peak_abs, period_last, locked};
            if (exp_q.size() == 0) begin
                check("unexpected_meas_valid", meas_valid, 0);
            end else begin
                e = exp_q.pop_front();
                check("mon_crossings", crossings, e[50:35]);
                check("mon_peak_abs", peak_abs, e[34:17]);
                check("mon_period_last", period_last, e[16:1]);
                check("mon_locked", locked, e[0]);
            end
        end
    end

    // ---------------- directed table ----------------
    typedef struct {
        int amp;
        int half;
        bit spike;
        int gap;
        int e_cross;
        int e_peak;
        int e_period;
        bit e_locked;
    } vec_t;

    vec_t tbl[6];

    task automatic check_zero(input string tag);
        check({tag, "_crossings"}, crossings, 0);
        check({tag, "_period_last"}, period_last, 0);
        check({tag, "_peak_abs"}, peak_abs, 0);
        check({tag, "_meas_valid"}, meas_valid, 0);
        check({tag, "_locked"}, locked, 0);
    endtask

    initial begin
        int n;
        int half;
        int amp;
        int sgn;
        int v;
        int idx;

        model_reset();
        // square wave +8192, toggles every 340 samples, clk_en every other cycle
        tbl[0] = '{8192, 340, 1'b0, 1, 11, 8192, 680, 1'b1};
        // chatter below hysteresis
        tbl[1] = '{30, 1, 1'b0, 0, 0, 30, 0, 1'b0};
        // single most-negative sample among zeros
        tbl[2] = '{XMINV, 1, 1'b1, 0, 0, XMAXV, 0, 1'b0};
        // faster square, continuous clk_en
        tbl[3] = '{1000, 100, 1'b0, 0, 39, 1000, 200, 1'b1};
        // amplitude exactly at threshold, starting negative
        tbl[4] = '{-HYST, 500, 1'b0, 0, 7, HYST, 1000, 1'b1};
        // amplitude one LSB below threshold
        tbl[5] = '{HYST-1, 500, 1'b0, 0, 0, HYST-1, 0, 1'b0};

        // Reset held with clk_en high: outputs stay zero.
        clk_en = 1'b1;
        x = 18'sd8192;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_zero("reset_hold");
        end
        rst = 1'b0;

        for (int t = 0; t < 6; t++) begin
            do_reset();
            pulse_cnt = 0;
            for (int i = 0; i < WINDOW; i++) begin
                v = tbl[t].spike ? ((i == 100) ? tbl[t].amp : 0) : sq(i, tbl[t].half, tbl[t].amp);
                step(1'b1, v);
                repeat (tbl[t].gap) step(1'b0, v);
            end
            repeat (4) step(1'b0, 0);
            check($sformatf("tbl%0d_pulses", t), pulse_cnt, 1);
            check($sformatf("tbl%0d_crossings", t), snap[50:35], tbl[t].e_cross);
            check($sformatf("tbl%0d_peak_abs", t), snap[34:17], tbl[t].e_peak);
            check($sformatf("tbl%0d_period_last", t), snap[16:1], tbl[t].e_period);
            check($sformatf("tbl%0d_locked", t), snap[0], tbl[t].e_locked);
        end

        // Gating: toggling x with clk_en low must not move anything.
        do_reset();
        for (int i = 0; i < WINDOW; i++) step(1'b1, sq(i, 340, 8192));
        repeat (40) step(1'b0, (($urandom_range(0, 1) == 1) ? 8192 : -8192));
        check("gate_crossings", crossings, 11);
        check("gate_peak_abs", peak_abs, 8192);
        check("gate_period_last", period_last, 680);
        check("gate_locked", locked, 1);
        for (int i = 0; i < 2000; i++) step(1'b1, sq(WINDOW + i, 340, 8192));

        // Reset mid-window discards the partial window.
        do_reset();
        check_zero("midrst");
        n = 0;
        while (n < WINDOW + 100) begin
            step(1'b1, sq(n, 340, 8192));
            if (meas_valid) break;
            n++;
        end
        check("midrst_samples_to_valid", n, WINDOW);
        repeat (3) step(1'b0, 0);

        // Randomized bursts checked against the reference model.
        do_reset();
        idx = 0;
        while (idx < 3 * WINDOW) begin
            half = $urandom_range(5, 300);
            amp  = $urandom_range(40, XMAXV);
            sgn  = ($urandom_range(0, 1) == 1) ? 1 : -1;
            for (int k = 0; k < half; k++) begin
                bit en;
                en = ($urandom_range(0, 9) < 7);
                v = sgn * amp + $urandom_range(0, 40) - 20;
                if ($urandom_range(0, 499) == 0) v = XMINV;
                if (v > XMAXV) v = XMAXV;
                if (v < XMINV) v = XMINV;
                step(en, v);
                if (en) idx++;
            end
        end
        repeat (4) step(1'b0, 0);
        check("rand_period_last", period_last, m_period);
        check("rand_locked", locked, m_locked);

`ifdef OSC_FREQ_METER_DIR_EN
        // Direction capture: y negative at rising x crossing -> dir=1.
        do_reset();
        for (int i = 0; i < 1200; i++) begin
            real th;
            th = 2.0 * 3.14159265358979 * i / 400.0;
            y = 18'($rtoi(8192.0 * $sin(th)));
            step(1'b1, $rtoi(8192.0 * $cos(th)));
        end
        step(1'b0, 0);
        check("dir_neg_y", dir, 1);
        for (int i = 1200; i < 2000; i++) begin
            real th;
            th = 2.0 * 3.14159265358979 * i / 400.0;
            y = 18'($rtoi(-8192.0 * $sin(th)));
            step(1'b1, $rtoi(8192.0 * $cos(th)));
        end
        step(1'b0, 0);
        check("dir_pos_y", dir, 0);
`endif

        check("exp_q_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
